// File: rtl/bp_pkg.sv
// Shared types and helpers for the BTB branch predictor: FSM encoding,
// PC index/tag extraction and direction-counter constants.
package bp_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } bp_state_t;

    // Word-aligned PCs: bits [1:0] never take part in indexing.
    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

    function automatic logic [63:0] weak_taken(input int ctr_w);
        return 64'd1 << (ctr_w - 1);
    endfunction

    function automatic logic [63:0] strong_taken(input int ctr_w);
        return (64'd1 << ctr_w) - 64'd1;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down direction counter with synchronous load; one per BTB entry.
module bp_sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    output logic [CTR_W-1:0] value
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc && (value != '1)) begin
            value <= value + CTR_W'(1);
        end else if (dec && (value != '0)) begin
            value <= value - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry direction counters, trained from ID,
// looked up combinationally from IF, with a sweep invalidate and perf counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic              upd_is_jump,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              flush_req,
    output logic              busy,
    output logic [PERF_W-1:0] cnt_update,
    output logic [PERF_W-1:0] cnt_mispredict
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_WEAK   = CTR_W'(weak_taken(CTR_W));
    localparam logic [CTR_W-1:0] CTR_STRONG = CTR_W'(strong_taken(CTR_W));

    bp_state_t          state;
    logic [IDX_W-1:0]   sweep_idx;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag    [ENTRIES];
    logic [ADDR_W-1:0]  target [ENTRIES];
    logic [CTR_W-1:0]   ctr    [ENTRIES];

    logic [IDX_W-1:0]   li;
    logic [TAG_W-1:0]   ltag;
    logic [IDX_W-1:0]   ui;
    logic [TAG_W-1:0]   utag;

    logic               accept;
    logic               u_hit;
    logic               u_pred_taken;
    logic               mispredict;
    logic               alloc;
    logic               u_inc;
    logic               u_dec;
    logic               u_load;
    logic [CTR_W-1:0]   u_load_val;

    assign li   = IDX_W'(pc_index(64'(if_pc), IDX_W));
    assign ltag = TAG_W'(pc_tag(64'(if_pc), IDX_W));
    assign ui   = IDX_W'(pc_index(64'(upd_pc), IDX_W));
    assign utag = TAG_W'(pc_tag(64'(upd_pc), IDX_W));

    assign busy        = (state == ST_SWEEP);
    assign pred_hit    = valid[li] && (tag[li] == ltag) && !busy;
    assign pred_taken  = pred_hit && ctr[li][CTR_W-1];
    assign pred_target = target[li];

    // A flush request wins over a coincident update; the update is simply lost.
    assign accept       = upd_valid && (state == ST_IDLE) && !flush_req;
    assign u_hit        = valid[ui] && (tag[ui] == utag);
    assign u_pred_taken = u_hit && ctr[ui][CTR_W-1];
    assign mispredict   = (u_pred_taken != upd_taken) ||
                          (u_pred_taken && upd_taken && (target[ui] != upd_target));
    assign alloc        = accept && !u_hit && upd_taken;

    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    always_comb begin
        u_inc      = 1'b0;
        u_dec      = 1'b0;
        u_load     = 1'b0;
        u_load_val = CTR_STRONG;
        if (u_hit) begin
            if (upd_is_jump) begin
                u_load = 1'b1;
            end else begin
                u_inc = upd_taken;
                u_dec = !upd_taken;
            end
        end else if (upd_taken) begin
            u_load     = 1'b1;
            u_load_val = upd_is_jump ? CTR_STRONG : CTR_WEAK;
        end
    end

    for (genvar e = 0; e < ENTRIES; e++) begin : g_ctr
        logic sel;
        assign sel = accept && (ui == IDX_W'(e));

        bp_sat_counter #(
            .CTR_W (CTR_W)
        ) u_ctr (
            .CLK      (CLK),
            .RST      (RST),
            .inc      (sel && u_inc),
            .dec      (sel && u_dec),
            .load     (sel && u_load),
            .load_val (u_load_val),
            .value    (ctr[e])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            sweep_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush_req) begin
                        state     <= ST_SWEEP;
                        sweep_idx <= '0;
                    end
                end
                ST_SWEEP: begin
                    sweep_idx <= sweep_idx + IDX_W'(1);
                    if (sweep_idx == IDX_W'(ENTRIES - 1)) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sweep and update never coincide: updates are only accepted in IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= '0;
        end else if (state == ST_SWEEP) begin
            valid[sweep_idx] <= 1'b0;
        end else if (alloc) begin
            valid[ui] <= 1'b1;
        end
    end

    // NOTE: tag/target storage is not reset; the valid bits alone gate their use.
    always_ff @(posedge CLK) begin
        if (alloc) begin
            tag[ui] <= utag;
        end
        if (accept && upd_taken) begin
            target[ui] <= upd_target;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_update     <= '0;
            cnt_mispredict <= '0;
        end else if (accept) begin
            if (cnt_update != '1) begin
                cnt_update <= cnt_update + PERF_W'(1);
            end
            if (mispredict && (cnt_mispredict != '1)) begin
                cnt_mispredict <= cnt_mispredict + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (16 entries, 2-bit
// counters, 5-bit perf counters so saturation is reached quickly).
module tb_branch_predictor;

    localparam int ADDR_W  = 32;
    localparam int ENTRIES = 16;
    localparam int CTR_W   = 2;
    localparam int PERF_W  = 5;

    logic              CLK;
    logic              RST;
    logic [ADDR_W-1:0] if_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic              upd_is_jump;
    logic [ADDR_W-1:0] upd_target;
    logic              flush_req;
    logic              busy;
    logic [PERF_W-1:0] cnt_update;
    logic [PERF_W-1:0] cnt_mispredict;

    int errors = 0;
    int checks = 0;

    branch_predictor #(
        .ADDR_W  (ADDR_W),
        .ENTRIES (ENTRIES),
        .CTR_W   (CTR_W),
        .PERF_W  (PERF_W)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .if_pc          (if_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_is_jump    (upd_is_jump),
        .upd_target     (upd_target),
        .flush_req      (flush_req),
        .busy           (busy),
        .cnt_update     (cnt_update),
        .cnt_mispredict (cnt_mispredict)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken, input logic jump,
                             input logic [31:0] tgt);
        upd_pc      = pc;
        upd_taken   = taken;
        upd_is_jump = jump;
        upd_target  = tgt;
        upd_valid   = 1'b1;
        tick();
        upd_valid   = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        if_pc = pc;
        #1;
    endtask

    localparam logic [31:0] PC_A = 32'h0040_0010;
    localparam logic [31:0] PC_B = 32'h0040_0050;
    localparam logic [31:0] PC_X = 32'h0040_0020;

    initial begin
        int n;
        int hits;

        RST         = 1'b1;
        if_pc       = '0;
        upd_valid   = 1'b0;
        upd_pc      = '0;
        upd_taken   = 1'b0;
        upd_is_jump = 1'b0;
        upd_target  = '0;
        flush_req   = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Reset state
        lookup(PC_A);
        check("rst_hit",      64'(pred_hit), 64'd0);
        check("rst_taken",    64'(pred_taken), 64'd0);
        check("rst_busy",     64'(busy), 64'd0);
        check("rst_cnt_upd",  64'(cnt_update), 64'd0);
        check("rst_cnt_misp", 64'(cnt_mispredict), 64'd0);

        // First taken update allocates weakly taken; lookup this cycle sees old contents
        upd_pc = PC_A; upd_taken = 1'b1; upd_is_jump = 1'b0; upd_target = 32'h0040_0040;
        upd_valid = 1'b1;
        #1;
        check("no_bypass_hit", 64'(pred_hit), 64'd0);
        tick();
        upd_valid = 1'b0;
        lookup(PC_A);
        check("alloc_hit",    64'(pred_hit), 64'd1);
        check("alloc_taken",  64'(pred_taken), 64'd1);
        check("alloc_target", 64'(pred_target), 64'h0040_0040);
        check("alloc_ctr",    64'(dut.ctr[4]), 64'd2);
        check("alloc_misp",   64'(cnt_mispredict), 64'd1);
        check("alloc_upd",    64'(cnt_update), 64'd1);

        // Two not-taken updates: 2 -> 1 -> 0, only the first mispredicts
        do_update(PC_A, 1'b0, 1'b0, 32'h0);
        lookup(PC_A);
        check("nt1_hit",   64'(pred_hit), 64'd1);
        check("nt1_taken", 64'(pred_taken), 64'd0);
        check("nt1_ctr",   64'(dut.ctr[4]), 64'd1);
        check("nt1_misp",  64'(cnt_mispredict), 64'd2);
        do_update(PC_A, 1'b0, 1'b0, 32'h0);
        lookup(PC_A);
        check("nt2_ctr",   64'(dut.ctr[4]), 64'd0);
        check("nt2_misp",  64'(cnt_mispredict), 64'd2);
        check("nt2_upd",   64'(cnt_update), 64'd3);

        // Alias: same index, different tag, replaces A
        do_update(PC_B, 1'b1, 1'b0, 32'h0040_0100);
        lookup(PC_A);
        check("alias_a_miss", 64'(pred_hit), 64'd0);
        lookup(PC_B);
        check("alias_b_hit",  64'(pred_hit), 64'd1);
        check("alias_b_tgt",  64'(pred_target), 64'h0040_0100);
        check("alias_misp",   64'(cnt_mispredict), 64'd3);

        // Jump with a new target: strong counter, target mispredict
        do_update(PC_B, 1'b1, 1'b1, 32'h0040_0200);
        lookup(PC_B);
        check("jump_ctr",  64'(dut.ctr[4]), 64'd3);
        check("jump_tgt",  64'(pred_target), 64'h0040_0200);
        check("jump_misp", 64'(cnt_mispredict), 64'd4);

        // Correct taken prediction: no mispredict, counter stays saturated
        do_update(PC_B, 1'b1, 1'b0, 32'h0040_0200);
        check("correct_ctr",  64'(dut.ctr[4]), 64'd3);
        check("correct_misp", 64'(cnt_mispredict), 64'd4);
        check("correct_upd",  64'(cnt_update), 64'd6);

        // Fill every entry (all misses with tag 0x10000)
        for (int i = 0; i < ENTRIES; i++) begin
            do_update(32'h0040_0000 + 32'(i * 4), 1'b1, 1'b0, 32'h0050_0000 + 32'(i));
        end
        hits = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            lookup(32'h0040_0000 + 32'(i * 4));
            if (pred_hit === 1'b1 && pred_target === 32'h0050_0000 + 32'(i)) hits++;
        end
        check("fill_hits", 64'(hits), 64'(ENTRIES));
        check("fill_upd",  64'(cnt_update), 64'd22);
        check("fill_misp", 64'(cnt_mispredict), 64'd20);

        // Flush with a coincident update (dropped), then count busy cycles
        flush_req = 1'b1;
        do_update(32'h0040_0080, 1'b1, 1'b0, 32'h0);
        flush_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n == 3) begin
                lookup(32'h0040_003C);
                check("sweep_hit_masked", 64'(pred_hit), 64'd0);
            end
            upd_valid = (n == 5);
            upd_pc = 32'h0040_0080; upd_taken = 1'b1; upd_is_jump = 1'b0;
            tick();
            n++;
        end
        upd_valid = 1'b0;
        check("sweep_len", 64'(n), 64'(ENTRIES));
        check("sweep_upd_dropped", 64'(cnt_update), 64'd22);
        hits = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            lookup(32'h0040_0000 + 32'(i * 4));
            if (pred_hit !== 1'b0) hits++;
        end
        check("post_sweep_hits", 64'(hits), 64'd0);

        // Perf counter saturation: alternating jump targets always mispredict
        for (int i = 0; i < 35; i++) begin
            do_update(PC_X, 1'b1, 1'b1, (i % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
            if (i == 9) begin
                check("sat_upd_at10",  64'(cnt_update), 64'd31);
                check("sat_misp_at10", 64'(cnt_mispredict), 64'd30);
            end
        end
        check("sat_upd",  64'(cnt_update), 64'd31);
        check("sat_misp", 64'(cnt_mispredict), 64'd31);

        // Reset mid-sweep
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        check("pre_rst_busy", 64'(busy), 64'd1);
        RST = 1'b1;
        lookup(PC_X);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_upd",  64'(cnt_update), 64'd0);
        check("midrst_misp", 64'(cnt_mispredict), 64'd0);
        check("midrst_hit",  64'(pred_hit), 64'd0);
        #1;
        RST = 1'b0;
        tick();
        check("post_rst_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with per-entry saturating direction counters for the five-stage MIPS pipeline. Looked up combinationally with the IF-stage PC to supply a predicted next PC to the PCU. Trained from the ID stage, where branches and jumps resolve, so taken branches no longer always cost a flush. Also provides a sweep-based invalidate and saturating performance counters.

## Interface
Parameters:
- `ADDR_W`, default 32: PC width in bits.
- `ENTRIES`, default 16: number of BTB entries; must be a power of two and at least 2. `IDX_W = log2(ENTRIES)`.
- `CTR_W`, default 2: width of each direction counter; at least 1.
- `PERF_W`, default 16: width of each performance counter.
- Derived: `TAG_W = ADDR_W - IDX_W - 2`.

Ports:
- `CLK` in 1: the block's single clock; all state changes on its rising edge.
- `RST` in 1: reset, asynchronous and active-high.
- `if_pc` in ADDR_W: PC being fetched.
- `pred_hit` out 1: valid entry whose tag matches `if_pc`.
- `pred_taken` out 1: predict taken.
- `pred_target` out ADDR_W: predicted target; meaningful only when `pred_taken`=1.
- `upd_valid` in 1: ID stage has resolved a branch or jump this cycle.
- `upd_pc` in ADDR_W: PC of the resolved instruction.
- `upd_taken` in 1: actual direction.
- `upd_is_jump` in 1: unconditional jump; `upd_taken` must also be 1.
- `upd_target` in ADDR_W: actual target.
- `flush_req` in 1: start invalidating the whole table.
- `busy` out 1: invalidate sweep in progress.
- `cnt_update` out PERF_W: number of accepted updates.
- `cnt_mispredict` out PERF_W: number of accepted updates that were mispredicted.

## Operation
- Address split: index = `pc[IDX_W+1:2]`; tag = `pc[ADDR_W-1:IDX_W+2]`.
- Each entry holds valid, tag, target and a counter.
- Lookup is purely combinational from the stored state:
  - `pred_hit` = valid & tag match & !busy.
  - `pred_taken` = `pred_hit` & counter MSB.
  - `pred_target` = stored target.
- Accepting an update (`upd_valid` & state IDLE & !`flush_req`) first reads the entry at the update index. It then evaluates the *prior* prediction:
  - predicted-taken = hit & counter MSB.
  - mispredict = (predicted-taken != `upd_taken`), or (both taken and stored target != `upd_target`).
- Update on a hit:
  - `upd_is_jump`: counter set to all ones, target written.
  - Otherwise: counter saturating +1 if taken, -1 if not taken. Target is written only when taken.
- Update on a miss:
  - Taken: allocate the entry (valid=1, new tag, target). Counter = all ones for a jump, else 2^(CTR_W-1) (weakly taken).
  - Not taken: no table change.
- Performance counters:
  - `cnt_update` increments on every accepted update.
  - `cnt_mispredict` increments on every accepted update flagged as mispredict.
  - Both saturate at all ones and never wrap.
- State machine:
  - IDLE → SWEEP on `flush_req`; the sweep index is cleared to 0.
  - In SWEEP, each cycle clears `valid[idx]` and increments idx. When idx = ENTRIES-1 the clear happens and the state returns to IDLE.
  - `flush_req` during SWEEP is ignored.
  - Tags, targets and counters are left untouched by the sweep.
- Updates during SWEEP, or coinciding with `flush_req` in IDLE, are dropped and not counted. The flush takes priority.

## Timing
- Reset values: state IDLE, all valid bits 0, counters 0, `cnt_*` 0, `busy` 0, `pred_hit`/`pred_taken` 0. `pred_target` value is don't-care after reset.
- Reset asserted mid-sweep returns the block to IDLE immediately.
- Lookup latency is 0 cycles (same-cycle combinational).
- Update latency is 1 cycle: an update accepted at edge N is first visible to lookup after edge N.
- Same index looked up and updated in the same cycle: the lookup sees the old contents. There is no bypass.
- Sweep duration: `busy` is high for exactly ENTRIES cycles, starting the cycle after `flush_req` is sampled.

## Structure
- Shared package `bp_pkg` holds:
  - state encoding (IDLE, SWEEP);
  - index/tag extraction functions;
  - the weak-taken and strong-taken counter constants.
- One sub-module, `bp_sat_counter`: CTR_W-bit saturating up/down counter with load. It is instanced per entry.
- The table is a flop array; no memory macro.

## Test plan
- Reset, then lookup `if_pc`=0x00400010 → `pred_hit`=0, `pred_taken`=0, `cnt_update`=0.
- Update pc=0x00400010, taken, target=0x00400040 (CTR_W=2) → next cycle lookup gives hit=1, taken=1, target=0x00400040; counter=2; `cnt_mispredict`=1.
- Two not-taken updates to the same pc → counter goes 2→1→0; `pred_taken`=0 after the first; `cnt_mispredict` rises by 1 (first update only).
- Alias: pc 0x00400010 and 0x00400050 (ENTRIES=16, same index, different tag); taken update of the second → lookup of the first misses. Jump update sets counter=3.
- `flush_req` with 16 valid entries → `busy` high for exactly 16 cycles; all lookups miss afterwards. An update issued mid-sweep is dropped and `cnt_update` is unchanged.
- 2^PERF_W+3 mispredicting updates → `cnt_mispredict` holds at all ones; `RST` pulsed mid-sweep → IDLE, `busy`=0, counters 0.
